// File: rtl/mem_lsu_seq_if.sv
// rtl/mem_lsu_seq_if.sv - core request/response and data memory signals of the load/store sequencer
interface mem_lsu_seq_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic              mem_byte_src;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_wd;
    logic [31:0]       mem_rd;

    // Sequencer view: takes core requests and memory read data, drives everything else
    modport master (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_byte_src, mem_a, mem_wd
    );

    // Environment view: the core and the data memory together
    modport slave (
        output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_byte_src, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_lsu_seq.sv
// rtl/mem_lsu_seq.sv - load/store sequencer, byte-serial stores; optional MEM_LSU_ALIGN_CHECK_EN
module mem_lsu_seq #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_lsu_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              byte_q;
    logic [31:0]       rdata_q;
    logic              misaligned;
    logic              last_beat;
    logic [7:0]        word_byte;
    logic              accept;

    logic              req_ready;
    logic              resp_valid;
    logic              mem_we;
    logic              mem_byte_src;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_wd;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign last_beat = byte_q || (beat == 2'd3);

`ifdef MEM_LSU_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned   = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
    assign bus.resp_err = (state == DONE) && err_q;

    // Remember whether the accepted request was rejected for alignment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
        end
    end
`else
    assign misaligned   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Big-endian byte lane for the current word-store beat
    always_comb begin
        word_byte = 8'h00;
        case (beat)
            2'd0:    word_byte = wdata_q[31:24];
            2'd1:    word_byte = wdata_q[23:16];
            2'd2:    word_byte = wdata_q[15:8];
            default: word_byte = wdata_q[7:0];
        endcase
    end

    // Next-state and memory/handshake decode; mem_* depend only on registered state
    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_we       = 1'b0;
        mem_byte_src = 1'b0;
        mem_a        = '0;
        mem_wd       = 8'h00;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (misaligned) begin
                        next_state = DONE;
                    end else if (bus.req_we) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            WR: begin
                mem_we = 1'b1;
                mem_a  = addr_q + {{(ADDR_W-2){1'b0}}, beat};
                mem_wd = byte_q ? wdata_q[7:0] : word_byte;
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            RD: begin
                mem_a        = addr_q;
                mem_byte_src = byte_q;
                next_state   = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the accepted request, step write beats, capture load data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat    <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            byte_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        byte_q  <= bus.req_byte;
                        beat    <= 2'd0;
                    end
                end
                WR: beat <= beat + 2'd1;
                RD: rdata_q <= byte_q ? {24'h0, bus.mem_rd[7:0]} : bus.mem_rd;
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_rdata   = rdata_q;
    assign bus.mem_we       = mem_we;
    assign bus.mem_byte_src = mem_byte_src;
    assign bus.mem_a        = mem_a;
    assign bus.mem_wd       = mem_wd;
endmodule

// File: tb/tb_mem_lsu_seq.sv
// tb/tb_mem_lsu_seq.sv - scoreboard bench for mem_lsu_seq with a 256-byte aliased data memory
module tb_mem_lsu_seq;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_lsu_seq_if #(.ADDR_W(ADDR_W)) bus ();

    mem_lsu_seq #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: 256 bytes, address bits above [7:0] alias
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] a8;

    assign a8 = bus.mem_a[7:0];
    assign bus.mem_rd = bus.mem_byte_src ? {24'h0, mem[a8]}
                                         : {mem[a8], mem[a8 + 8'd1], mem[a8 + 8'd2], mem[a8 + 8'd3]};

    always @(posedge clk) if (bus.mem_we) mem[a8] <= bus.mem_wd;

    // Reference model state and scoreboard queues
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } beat_t;

    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [31:0] ref_rdata = 32'h0;
    resp_t       resp_q[$];
    beat_t       beat_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one accepted request, from the memory semantics alone
    task automatic model(input logic we, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input int acc);
        logic  misal;
        int    nb;
        beat_t b;
        resp_t r;
        misal = 1'b0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        misal = !byt && (addr % 4 != 0);
`endif
        if (misal) begin
            r = '{rdata: ref_rdata, err: 1'b1, cyc: acc};
        end else if (we) begin
            nb = byt ? 1 : 4;
            for (int i = 0; i < nb; i++) begin
                b.a = addr + i;
                b.d = byt ? wdata[7:0] : 8'(wdata >> (8 * (3 - i)));
                beat_q.push_back(b);
                ref_mem[b.a % 256] = b.d;
            end
            r = '{rdata: ref_rdata, err: 1'b0, cyc: acc + nb};
        end else begin
            if (byt) begin
                ref_rdata = {24'h0, ref_mem[addr % 256]};
            end else begin
                ref_rdata = 32'h0;
                for (int i = 0; i < 4; i++) ref_rdata = (ref_rdata << 8) | ref_mem[(addr + i) % 256];
            end
            r = '{rdata: ref_rdata, err: 1'b0, cyc: acc + 1};
        end
        resp_q.push_back(r);
    endtask

    // Present a request and wait for acceptance; returns #1 after the accepting edge
    task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int t;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            t++;
            if (t > 50) begin
                check("accept_timeout", 32'h0, 32'h1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        model(we, byt, addr, wdata, cyc);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
    endtask

    // Monitor: compare memory beats and responses as the DUT presents them
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_we) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", bus.mem_a, 32'hxxxx_xxxx);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_addr", bus.mem_a, b.a);
                    check("beat_data", {24'h0, bus.mem_wd}, {24'h0, b.d});
                end
            end
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", bus.resp_rdata, 32'hxxxx_xxxx);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_rdata", bus.resp_rdata, r.rdata);
                    check("resp_err", {31'h0, bus.resp_err}, {31'h0, r.err});
                    check("resp_cycle", cyc, r.cyc);
                end
            end
            if (bus.req_ready) check("idle_mem", {bus.mem_we, bus.mem_a[30:0]}, 32'h0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] save12, save13;
        int         t;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_resp", {bus.resp_valid, bus.resp_err, bus.mem_we, bus.mem_byte_src}, 32'h0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wd", {24'h0, bus.mem_wd}, 32'h0);
        @(posedge clk);
        #1;

        // Reset in the middle of a word store, after beat 1 has been written
        save12 = ref_mem[8'h12];
        save13 = ref_mem[8'h13];
        do_req(1'b1, 1'b0, 32'h10, 32'hCAFEF00D);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        beat_q.delete();
        resp_q.delete();
        ref_mem[8'h12] = save12;
        ref_mem[8'h13] = save13;
        ref_rdata = 32'h0;
        #1;
        check("midrst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("midrst_ready", {31'h0, bus.req_ready}, 32'h1);
        check("midrst_resp", {31'h0, bus.resp_valid}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("midrst_bytes", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]},
              {8'hCA, 8'hFE, save12, save13});
        do_req(1'b0, 1'b0, 32'h10, 32'h0);

        // Directed cases, issued back to back with req_valid held
        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 1'b1, 32'h21, 32'h123456A5);
        do_req(1'b0, 1'b1, 32'h21, 32'h0);
        do_req(1'b1, 1'b0, 32'hFFFFFFFE, 32'h01020304);
        do_req(1'b0, 1'b0, 32'hFFFFFFFE, 32'h0);
        do_req(1'b0, 1'b0, 32'h13, 32'h0);
        do_req(1'b1, 1'b0, 32'h13, 32'h55AA33CC);
        do_req(1'b0, 1'b1, 32'h15, 32'h0);

        // Randomized traffic with random gaps
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFF8 + $urandom_range(0, 7);
            else addr = $urandom_range(0, 63);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            do_req(1'($urandom), 1'($urandom), addr, $urandom);
        end

        t = 0;
        while ((resp_q.size() != 0 || beat_q.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain", resp_q.size() + beat_q.size(), 32'h0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
